clk_gate_ctrl: RTL and testbench

Controller that generates the enable for the downstream clock-gating cell. It runs on the free-running clock and watches a block-activity level. After a programmable run of idle cycles it drops the gate enable. On renewed activity it restores the enable and holds off a ready indication until a fixed wake-up settling period has elapsed. It also keeps a saturating count of gating events for power-debug visibility.

---
 rtl/clk_gate_pkg.sv | 20 ++
 rtl/cg_sat_counter.sv | 20 ++
 rtl/clk_gate_ctrl.sv | 119 +++++++++++
 tb/tb_clk_gate_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and defaults for the clock-gate enable controller.
// Holds the controller state encoding and default timing constants.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } cg_state_t;

  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_STAT_W      = 16;

  // A cycle counts toward gating only when nothing asks for the clock.
  function automatic logic is_idle(input logic activity, input logic force_on);
    return !activity && !force_on;
  endfunction

endpackage

// File: rtl/cg_sat_counter.sv
// Saturating up-counter used for power-debug event statistics.
// Holds at all-ones instead of wrapping.
module cg_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Generates the enable for a downstream clock-gating cell from an activity level.
// Gates after a run of idle cycles; on wake, delays ready until the domain settles.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int STAT_W      = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              activity,
  input  logic              force_on,
  output logic              gate_en,
  output logic              ready,
  output logic              gated,
  output logic [STAT_W-1:0] gate_events
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  cg_state_t     state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WW-1:0] wake_cnt_q, wake_cnt_d;
  logic          gate_en_q, gate_en_d;
  logic          ready_q, ready_d;
  logic          gated_q, gated_d;
  logic          gate_evt;
  logic          idle;

  assign idle = is_idle(activity, force_on);

  // Outputs are decided one cycle ahead and registered, so gate_en never glitches.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    gate_en_d  = gate_en_q;
    ready_d    = ready_q;
    gated_d    = gated_q;
    gate_evt   = 1'b0;
    case (state_q)
      RUN: begin
        if (!idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = GATED;
          gate_en_d  = 1'b0;
          ready_d    = 1'b0;
          gated_d    = 1'b1;
          idle_cnt_d = '0;
          gate_evt   = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      GATED: begin
        if (activity || force_on) begin
          state_d    = WAKE;
          gate_en_d  = 1'b1;
          gated_d    = 1'b0;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        // Inputs are deliberately ignored here: a started wake always finishes.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = RUN;
          ready_d    = 1'b1;
          wake_cnt_d = '0;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d    = RUN;
        gate_en_d  = 1'b1;
        ready_d    = 1'b1;
        gated_d    = 1'b0;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      gate_en_q  <= 1'b1;
      ready_q    <= 1'b1;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      gate_en_q  <= gate_en_d;
      ready_q    <= ready_d;
      gated_q    <= gated_d;
    end
  end

  cg_sat_counter #(.W(STAT_W)) u_events (
    .clk   (clk),
    .rst   (rst),
    .inc   (gate_evt),
    .count (gate_events)
  );

  assign gate_en = gate_en_q;
  assign ready   = ready_q;
  assign gated   = gated_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed scenarios plus random traffic against a reference model.
// A second instance with a 2-bit event counter exercises saturation.
module tb_clk_gate_ctrl;

  localparam int IDLE_N = 16;
  localparam int WAKE_N = 2;

  logic        clk = 1'b0;
  logic        rst, activity, force_on;
  logic        gate_en, ready, gated;
  logic [15:0] gate_events;
  logic        gate_en_s, ready_s, gated_s;
  logic [1:0]  gate_events_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: whether the domain is gated, how many settle cycles remain,
  // the length of the current idle run, and the event totals.
  bit m_gated;
  int m_wake_left;
  int m_idle_run;
  int m_ev;
  int m_ev_s;

  always #5 clk = ~clk;

  clk_gate_ctrl #(.IDLE_CYCLES(IDLE_N), .WAKE_CYCLES(WAKE_N), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .activity(activity), .force_on(force_on),
    .gate_en(gate_en), .ready(ready), .gated(gated), .gate_events(gate_events)
  );

  clk_gate_ctrl #(.IDLE_CYCLES(IDLE_N), .WAKE_CYCLES(WAKE_N), .STAT_W(2)) dut_s (
    .clk(clk), .rst(rst), .activity(activity), .force_on(force_on),
    .gate_en(gate_en_s), .ready(ready_s), .gated(gated_s), .gate_events(gate_events_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit a, input bit f);
    if (r) begin
      m_gated = 0; m_wake_left = 0; m_idle_run = 0; m_ev = 0; m_ev_s = 0;
    end else if (m_gated) begin
      if (a || f) begin
        m_gated     = 0;
        m_wake_left = WAKE_N;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left--;
      m_idle_run = 0;
    end else if (!a && !f) begin
      m_idle_run++;
      if (m_idle_run == IDLE_N) begin
        m_gated    = 1;
        m_idle_run = 0;
        m_ev       = (m_ev == 65535) ? m_ev : m_ev + 1;
        m_ev_s     = (m_ev_s == 3) ? m_ev_s : m_ev_s + 1;
      end
    end else begin
      m_idle_run = 0;
    end
  endtask

  task automatic step(input bit r, input bit a, input bit f);
    rst = r; activity = a; force_on = f;
    @(posedge clk);
    model_edge(r, a, f);
    #1;
    chk("gate_en",     32'(gate_en),       32'(!m_gated));
    chk("ready",       32'(ready),         32'(!m_gated && m_wake_left == 0));
    chk("gated",       32'(gated),         32'(m_gated));
    chk("gate_events", 32'(gate_events),   32'(m_ev));
    chk("gate_en_s",   32'(gate_en_s),     32'(!m_gated));
    chk("ready_s",     32'(ready_s),       32'(!m_gated && m_wake_left == 0));
    chk("gated_s",     32'(gated_s),       32'(m_gated));
    chk("events_s",    32'(gate_events_s), 32'(m_ev_s));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic wake_up();
    step(0, 1, 0);
    idle_steps(WAKE_N);
  endtask

  initial begin
    int exp_sat [5] = '{1, 2, 3, 3, 3};
    int mode;
    rst = 1'b1; activity = 1'b0; force_on = 1'b0;
    m_gated = 0; m_wake_left = 0; m_idle_run = 0; m_ev = 0; m_ev_s = 0;

    // Reset and busy hold.
    step(1, 1, 0);
    step(1, 1, 0);
    chk("rst_gate_en", 32'(gate_en), 32'd1);
    chk("rst_ready",   32'(ready),   32'd1);
    chk("rst_gated",   32'(gated),   32'd0);
    chk("rst_events",  32'(gate_events), 32'd0);
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    chk("busy_gate_en", 32'(gate_en), 32'd1);

    // Gating after exactly IDLE_N idle edges.
    idle_steps(IDLE_N - 1);
    chk("idle15_gated", 32'(gated), 32'd0);
    step(0, 0, 0);
    chk("idle16_gated",   32'(gated),       32'd1);
    chk("idle16_gate_en", 32'(gate_en),     32'd0);
    chk("idle16_events",  32'(gate_events), 32'd1);

    // Wake with activity dropped after one edge.
    step(0, 1, 0);
    chk("wakeN_gate_en", 32'(gate_en), 32'd1);
    chk("wakeN_gated",   32'(gated),   32'd0);
    chk("wakeN_ready",   32'(ready),   32'd0);
    step(0, 0, 0);
    chk("wakeN1_ready", 32'(ready), 32'd0);
    step(0, 0, 0);
    chk("wakeN2_ready", 32'(ready), 32'd1);

    // Activity pulse at edge 15 restarts the idle run.
    idle_steps(14);
    step(0, 1, 0);
    idle_steps(15);
    chk("pulse30_gated", 32'(gated), 32'd0);
    step(0, 0, 0);
    chk("pulse31_gated", 32'(gated), 32'd1);

    // force_on keeps the clock running; release then re-gates after IDLE_N.
    wake_up();
    for (int i = 0; i < 100; i++) step(0, 0, 1);
    chk("force_gate_en", 32'(gate_en),     32'd1);
    chk("force_events",  32'(gate_events), 32'd2);
    idle_steps(IDLE_N - 1);
    chk("rel15_gated", 32'(gated), 32'd0);
    step(0, 0, 0);
    chk("rel16_gated", 32'(gated), 32'd1);

    // Reset while gated, then reset mid-wake.
    step(1, 0, 0);
    chk("rstG_gate_en", 32'(gate_en),     32'd1);
    chk("rstG_ready",   32'(ready),       32'd1);
    chk("rstG_gated",   32'(gated),       32'd0);
    chk("rstG_events",  32'(gate_events), 32'd0);
    idle_steps(IDLE_N);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("rstW_ready",  32'(ready),       32'd1);
    chk("rstW_events", 32'(gate_events), 32'd0);
    idle_steps(IDLE_N - 1);
    chk("rstW15_gated", 32'(gated), 32'd0);
    step(0, 0, 0);
    chk("rstW16_gated", 32'(gated), 32'd1);

    // Saturation of the 2-bit counter over five gating cycles.
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      idle_steps(IDLE_N);
      chk("sat_events_s", 32'(gate_events_s), 32'(exp_sat[k]));
      wake_up();
    end

    // Random traffic in phases of differing activity density.
    step(1, 0, 0);
    for (int p = 0; p < 80; p++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 50; i++) begin
        case (mode)
          0:       step($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0, 1'b0);
          1:       step($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, 1'b0);
          default: step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
                        $urandom_range(0, 19) == 0);
        endcase
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
